// File: rtl/lcd_pkg.sv
// Shared state encoding and HD44780 command constants for the LCD message sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        CLRWAIT,
        HOME,
        MSG,
        DONE
    } state_e;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h80;
    localparam logic [7:0] RS_MIN    = 8'h30;

    // Power-up init command ROM, in send order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC;
            2'd1:    return CMD_DISP;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_msg_buf.sv
// Message buffer: MSG_LEN x 8 register file, one synchronous write port and one
// combinational read port, filled with ASCII '0' on reset.
module lcd_msg_buf
    import lcd_pkg::*;
#(
    parameter int MSG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [7:0] wdata,
    input  logic [4:0] raddr,
    output logic [7:0] rdata
);

    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic [7:0] mem_q [MSG_LEN];

    // NOTE: the buffer is reset on purpose -- the message after reset must read as all '0' chars.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                mem_q[i] <= RS_MIN;
            end
        end else if (we && (int'(waddr) < MSG_LEN)) begin
            mem_q[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < MSG_LEN) ? mem_q[raddr[AW-1:0]] : RS_MIN;

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Byte source for lcd_wrapper: HD44780 power-up init, then cursor-home plus the
// buffered message, one byte per lcd_ready pulse; start re-sends home + message.
module lcd_msg_sequencer
    import lcd_pkg::*;
#(
    parameter int         MSG_LEN     = 16,
    parameter int         POWERUP_DLY = 20000,
    parameter int         CLR_DLY     = 2000,
    parameter logic [7:0] SUB_CHAR    = 8'h5F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       msg_we,
    input  logic [4:0] msg_addr,
    input  logic [7:0] msg_wdata,
    input  logic       lcd_ready,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done
);

    localparam int CNT_MAX = (POWERUP_DLY > CLR_DLY) ? POWERUP_DLY : CLR_DLY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_DLY - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_DLY - 1);
    localparam logic [4:0]       IDX_LAST = 5'(MSG_LEN - 1);

    state_e           state_q;
    logic [4:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       data_q;
    logic             busy_q;
    logic             done_q;
    logic [4:0]       rd_addr;
    logic [7:0]       rd_data;

    // Chars that would decode as commands downstream are replaced so RS stays 1.
    function automatic logic [7:0] fix(input logic [7:0] c);
        return ((c < RS_MIN) || (c == CMD_FUNC)) ? SUB_CHAR : c;
    endfunction

    // The read port always looks one char ahead of the byte currently on lcd_data.
    assign rd_addr = (state_q == MSG) ? (idx_q + 5'd1) : 5'd0;

    lcd_msg_buf #(
        .MSG_LEN(MSG_LEN)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (msg_we),
        .waddr(msg_addr),
        .wdata(msg_wdata),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PWRUP;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= CMD_FUNC;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                PWRUP: begin
                    if (cnt_q == PWR_LAST) begin
                        state_q <= INIT;
                        idx_q   <= '0;
                        data_q  <= CMD_FUNC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                INIT: begin
                    if (lcd_ready) begin
                        if (idx_q < 5'd3) begin
                            idx_q  <= idx_q + 5'd1;
                            data_q <= init_cmd(idx_q[1:0] + 2'd1);
                        end else begin
                            state_q <= CLRWAIT;
                            data_q  <= CMD_FUNC;
                            cnt_q   <= '0;
                        end
                    end
                end
                CLRWAIT: begin
                    if (cnt_q == CLR_LAST) begin
                        state_q <= HOME;
                        data_q  <= CMD_HOME;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOME: begin
                    if (lcd_ready) begin
                        state_q <= MSG;
                        idx_q   <= '0;
                        data_q  <= fix(rd_data);
                    end
                end
                MSG: begin
                    if (lcd_ready) begin
                        if (idx_q < IDX_LAST) begin
                            idx_q  <= idx_q + 5'd1;
                            data_q <= fix(rd_data);
                        end else begin
                            state_q <= DONE;
                            data_q  <= CMD_FUNC;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= HOME;
                        data_q  <= CMD_HOME;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= PWRUP;
                    cnt_q   <= '0;
                    data_q  <= CMD_FUNC;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Scoreboard bench for lcd_msg_sequencer: stimulus pushes the expected byte stream,
// a negedge monitor compares lcd_data/busy/done and pops a byte on each ready pulse.
module tb_lcd_msg_sequencer;

    localparam int MSG_LEN     = 4;
    localparam int POWERUP_DLY = 8;
    localparam int CLR_DLY     = 4;

    typedef enum {P_NONE, P_CLRWAIT, P_DONE} post_e;
    typedef struct {
        logic [7:0] b;
        post_e      post;
    } item_t;
    typedef enum {RDY_OFF, RDY_PER5, RDY_RAND} rdy_mode_e;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       msg_we;
    logic [4:0] msg_addr;
    logic [7:0] msg_wdata;
    logic       lcd_ready;
    logic [7:0] lcd_data;
    logic       busy;
    logic       done;

    int         n_vec = 0;
    int         n_bad = 0;
    item_t      exp_q[$];
    item_t      popped;
    logic [7:0] exp_buf [MSG_LEN];
    int         wait_left = 0;
    bit         in_done = 1'b0;
    rdy_mode_e  rdy_mode = RDY_PER5;

    lcd_msg_sequencer #(
        .MSG_LEN    (MSG_LEN),
        .POWERUP_DLY(POWERUP_DLY),
        .CLR_DLY    (CLR_DLY),
        .SUB_CHAR   (8'h5F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .msg_we   (msg_we),
        .msg_addr (msg_addr),
        .msg_wdata(msg_wdata),
        .lcd_ready(lcd_ready),
        .lcd_data (lcd_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference substitution: anything below '0', or '8' itself, becomes '_'.
    function automatic logic [7:0] ref_fix(input logic [7:0] c);
        if (c < 8'h30 || c == 8'h38) return 8'h5F;
        return c;
    endfunction

    function automatic void push_item(input logic [7:0] b, input post_e p);
        item_t it;
        it.b    = b;
        it.post = p;
        exp_q.push_back(it);
    endfunction

    function automatic void push_start_seq();
        push_item(8'h80, P_NONE);
        for (int i = 0; i < MSG_LEN; i++) begin
            push_item(ref_fix(exp_buf[i]), (i == MSG_LEN - 1) ? P_DONE : P_NONE);
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < MSG_LEN; i++) exp_buf[i] = 8'h30;
        push_item(8'h38, P_NONE);
        push_item(8'h0C, P_NONE);
        push_item(8'h06, P_NONE);
        push_item(8'h01, P_CLRWAIT);
        push_start_seq();
        wait_left = POWERUP_DLY;
        in_done   = 1'b0;
    endfunction

    // Monitor: every negedge compares outputs against what the model says is showing.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_data", lcd_data, 8'h38);
            check("rst_busy", {7'b0, busy}, 8'h01);
            check("rst_done", {7'b0, done}, 8'h00);
        end else if (wait_left > 0) begin
            check("wait_data", lcd_data, 8'h38);
            check("wait_busy", {7'b0, busy}, 8'h01);
            check("wait_done", {7'b0, done}, 8'h00);
            wait_left--;
        end else if (in_done) begin
            check("done_data", lcd_data, 8'h38);
            check("done_busy", {7'b0, busy}, 8'h00);
            check("done_done", {7'b0, done}, 8'h01);
            if (start) in_done = 1'b0;
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL no_expected_byte: got %02h, expected nothing at %0t", lcd_data, $time);
        end else begin
            check("send_data", lcd_data, exp_q[0].b);
            check("send_busy", {7'b0, busy}, 8'h01);
            check("send_done", {7'b0, done}, 8'h00);
            if (lcd_ready) begin
                popped = exp_q.pop_front();
                if (popped.post == P_CLRWAIT) wait_left = CLR_DLY;
                else if (popped.post == P_DONE) in_done = 1'b1;
            end
        end
    end

    // Ready source standing in for lcd_wrapper.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            if (rdy_mode == RDY_PER5) lcd_ready = (k % 5 == 0);
            else if (rdy_mode == RDY_RAND) lcd_ready = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input int a, input logic [7:0] d);
        tick();
        msg_we    = 1'b1;
        msg_addr  = 5'(a);
        msg_wdata = d;
        if (a < MSG_LEN) exp_buf[a] = d;
        tick();
        msg_we = 1'b0;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        push_start_seq();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!(in_done && exp_q.size() == 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (!(in_done && exp_q.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout_done: %0d bytes still pending after %0d cycles", exp_q.size(), budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_qsize(input int n, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != n) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout_qsize: size %0d, expected %0d", exp_q.size(), n);
        end
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        msg_we    = 1'b0;
        msg_addr  = '0;
        msg_wdata = '0;
        lcd_ready = 1'b0;
        model_reset();
        #2 rst = 1'b0;

        // Power-up and init with a ready pulse every 5 cycles, including during waits.
        repeat (3) tick();
        rst = 1'b1;
        wait_done(500);

        // "HI7A" re-sent on start.
        rdy_mode = RDY_RAND;
        write_buf(0, 8'h48);
        write_buf(1, 8'h49);
        write_buf(2, 8'h37);
        write_buf(3, 8'h41);
        do_start();
        wait_done(300);

        // "a 8!" exercises the substitution rule.
        write_buf(0, 8'h61);
        write_buf(1, 8'h20);
        write_buf(2, 8'h38);
        write_buf(3, 8'h21);
        do_start();
        wait_done(300);

        // start and an out-of-range write during MSG have no effect.
        do_start();
        wait_qsize(2, 300);
        start     = 1'b1;
        msg_we    = 1'b1;
        msg_addr  = 5'd4;
        msg_wdata = 8'h5A;
        tick();
        start  = 1'b0;
        msg_we = 1'b0;
        wait_done(300);
        do_start();
        wait_done(300);

        // Reset at message index 2 aborts and restores the '0' buffer.
        write_buf(0, 8'h57);
        write_buf(1, 8'h58);
        write_buf(2, 8'h59);
        write_buf(3, 8'h5A);
        do_start();
        wait_qsize(2, 300);
        rst = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        wait_done(600);

        // start with ready in DONE, then ready stuck low in HOME, then one pulse.
        write_buf(0, 8'h4F);
        write_buf(1, 8'h4B);
        rdy_mode  = RDY_OFF;
        lcd_ready = 1'b0;
        tick();
        start     = 1'b1;
        lcd_ready = 1'b1;
        push_start_seq();
        tick();
        start     = 1'b0;
        lcd_ready = 1'b0;
        repeat (50) tick();
        lcd_ready = 1'b1;
        tick();
        lcd_ready = 1'b0;
        repeat (8) tick();
        rdy_mode = RDY_RAND;
        wait_done(300);

        // Random buffer contents, including out-of-range addresses.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 3; w++) begin
                write_buf(int'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            end
            do_start();
            wait_done(300);
        end

        check("queue_empty", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
